// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared state type, shift width and saturating add for the MAC return path
package mac_pkg;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    CONV   = 2'd1,
    OUTPUT = 2'd2
  } acc_state_e;

  localparam int SHIFT_W = 5;

  // Adds two sign-extended operands and clamps the sum to a w-bit signed range (w <= 62).
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    if (sum > hi)
      return hi;
    else if (sum < lo)
      return lo;
    else
      return sum;
  endfunction

endpackage

// File: rtl/tc2sm.sv
// rtl/tc2sm.sv - combinational round-half-up shift, abs and clip to sign-magnitude
module tc2sm
  import mac_pkg::*;
#(
  parameter int DW   = 8,
  parameter int ACCW = 24
) (
  input  logic signed [ACCW-1:0]  acc,
  input  logic        [SHIFT_W-1:0] shift,
  output logic        [DW-1:0]    mag,
  output logic                    sign,
  output logic                    sat
);

  localparam logic [ACCW:0] MAX_MAG = (ACCW+1)'((1 << DW) - 1);

  logic signed [ACCW:0] wide;
  logic signed [ACCW:0] rnd;
  logic signed [ACCW:0] r;
  logic        [ACCW:0] m;

  // One extra bit keeps the rounding add and the abs of the most negative value exact.
  always_comb begin
    wide = (ACCW+1)'(acc);
    rnd  = '0;
    if (shift != '0)
      rnd = (ACCW+1)'(1) <<< (shift - 1'b1);
    r    = (wide + rnd) >>> shift;
    sign = r[ACCW];
    m    = sign ? $unsigned(-r) : $unsigned(r);
    sat  = (m > MAX_MAG);
    mag  = sat ? '1 : m[DW-1:0];
  end

endmodule

// File: rtl/acc_sm_enc.sv
// rtl/acc_sm_enc.sv - group accumulator with requantised sign-magnitude output; MAC_ACC_SAT_EN enables saturating accumulation
module acc_sm_enc
  import mac_pkg::*;
#(
  parameter int DW   = 8,
  parameter int ACCW = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [2*DW:0] in_data,
  input  logic                 in_last,
  input  logic [SHIFT_W-1:0]   cfg_shift,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_mag,
  output logic                 out_sign,
  output logic                 out_sat
);

  acc_state_e             state;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] acc_next;
  logic [SHIFT_W-1:0]     shift_q;
  logic [SHIFT_W-1:0]     shift_clamped;
  logic                   sat_flag;
  logic                   sat_next;
  logic [DW-1:0]          conv_mag;
  logic                   conv_sign;
  logic                   conv_sat;

`ifdef MAC_ACC_SAT_EN
  logic signed [63:0] acc_w;
  logic signed [63:0] data_w;
  logic signed [63:0] sum_w;

  always_comb begin
    acc_w    = 64'(acc);
    data_w   = 64'(in_data);
    sum_w    = sat_add(acc_w, data_w, ACCW);
    acc_next = sum_w[ACCW-1:0];
    sat_next = sat_flag | (sum_w != (acc_w + data_w));
  end
`else
  always_comb begin
    acc_next = acc + ACCW'(in_data);
    sat_next = 1'b0;
  end
`endif

  always_comb begin
    shift_clamped = cfg_shift;
    if (int'(cfg_shift) >= ACCW)
      shift_clamped = SHIFT_W'(ACCW - 1);
  end

  tc2sm #(
    .DW   (DW),
    .ACCW (ACCW)
  ) u_tc2sm (
    .acc   (acc),
    .shift (shift_q),
    .mag   (conv_mag),
    .sign  (conv_sign),
    .sat   (conv_sat)
  );

  // in_ready is high only in ACCUM, so a transfer there is simply in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      shift_q   <= '0;
      sat_flag  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_sign  <= 1'b0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc      <= acc_next;
            sat_flag <= sat_next;
            if (in_last) begin
              shift_q  <= shift_clamped;
              in_ready <= 1'b0;
              state    <= CONV;
            end
          end
        end
        CONV: begin
          out_mag   <= conv_mag;
          out_sign  <= conv_sign;
          out_sat   <= conv_sat | sat_flag;
          out_valid <= 1'b1;
          state     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            sat_flag  <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
